// File: rtl/pc_gen.sv
// Fetch program-counter generator with valid/ready handshake and redirect buffering.
// Optional PC_ALIGN_CHECK_EN adds the misaligned-target ERR state.
module pc_gen #(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                STEP     = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_i,
   input  logic              req_ready_i,
   input  logic              flush_i,
   input  logic [ADDR_W-1:0] flush_pc_i,
   input  logic              br_flag_i,
   input  logic [ADDR_W-1:0] br_target_i,
   output logic [ADDR_W-1:0] pc_o,
   output logic              ce_o,
   output logic              redir_o,
   output logic              misalign_o
);

   typedef enum logic [1:0] {
      S_RESET,
      S_RUN,
      S_PEND,
      S_ERR
   } state_t;

   localparam logic [ADDR_W-1:0] INC = ADDR_W'(STEP);
`ifdef PC_ALIGN_CHECK_EN
   localparam logic [ADDR_W-1:0] MASK = ADDR_W'(STEP - 1);
`endif

   state_t            state, state_nx;
   logic [ADDR_W-1:0] pc_q, pc_nx;
   logic [ADDR_W-1:0] pend_q, pend_nx;
   logic              redir_q, redir_nx;
   logic              accept;
   logic              load;

   assign accept = ce_o & req_ready_i & ~stall_i;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_RESET;
         pc_q    <= RESET_PC;
         pend_q  <= '0;
         redir_q <= 1'b0;
      end else begin
         state   <= state_nx;
         pc_q    <= pc_nx;
         pend_q  <= pend_nx;
         redir_q <= redir_nx;
      end
   end

   always_comb begin
      state_nx = state;
      pc_nx    = pc_q;
      pend_nx  = pend_q;
      redir_nx = redir_q;
      load     = 1'b0;
      unique case (state)
         S_RESET: begin
            state_nx = S_RUN;
            pc_nx    = RESET_PC;
            redir_nx = 1'b0;
         end
         S_RUN: begin
            if (flush_i) begin
               pc_nx = flush_pc_i;
               load  = 1'b1;
            end else if (br_flag_i && accept) begin
               pc_nx = br_target_i;
               load  = 1'b1;
            end else if (br_flag_i) begin
               pend_nx  = br_target_i;
               state_nx = S_PEND;
            end else if (accept) begin
               pc_nx    = pc_q + INC;
               redir_nx = 1'b0;
            end
         end
         S_PEND: begin
            if (flush_i) begin
               pc_nx = flush_pc_i;
               load  = 1'b1;
            end else if (br_flag_i && accept) begin
               pc_nx = br_target_i;
               load  = 1'b1;
            end else if (br_flag_i) begin
               pend_nx = br_target_i;
            end else if (accept) begin
               pc_nx = pend_q;
               load  = 1'b1;
            end
         end
`ifdef PC_ALIGN_CHECK_EN
         S_ERR: begin
            if (flush_i) begin
               pc_nx = flush_pc_i;
               load  = 1'b1;
            end
         end
`endif
         default: begin
            state_nx = S_RESET;
            pc_nx    = RESET_PC;
            redir_nx = 1'b0;
         end
      endcase
      if (load) begin
         state_nx = S_RUN;
         redir_nx = 1'b1;
`ifdef PC_ALIGN_CHECK_EN
         // A misaligned target parks in ERR with fetch disabled.
         if (|(pc_nx & MASK)) begin
            state_nx = S_ERR;
            redir_nx = 1'b0;
         end
`endif
      end
   end

   always_comb begin
      pc_o       = pc_q;
      redir_o    = redir_q;
      ce_o       = (state == S_RUN) || (state == S_PEND);
`ifdef PC_ALIGN_CHECK_EN
      misalign_o = (state == S_ERR);
`else
      misalign_o = 1'b0;
`endif
   end

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: reset, hold, blocked branch, priority, wrap, alignment.
// A second 8-bit instance exercises address wrap-around.
module tb_pc_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_i;
   logic        req_ready_i;
   logic        flush_i;
   logic [31:0] flush_pc_i;
   logic        br_flag_i;
   logic [31:0] br_target_i;
   logic [31:0] pc_o;
   logic        ce_o;
   logic        redir_o;
   logic        misalign_o;

   logic [7:0]  w_pc;
   logic        w_ce;
   logic        w_redir;
   logic        w_mis;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pc_gen dut (
      .clk         (clk),
      .rst         (rst),
      .stall_i     (stall_i),
      .req_ready_i (req_ready_i),
      .flush_i     (flush_i),
      .flush_pc_i  (flush_pc_i),
      .br_flag_i   (br_flag_i),
      .br_target_i (br_target_i),
      .pc_o        (pc_o),
      .ce_o        (ce_o),
      .redir_o     (redir_o),
      .misalign_o  (misalign_o)
   );

   pc_gen #(
      .ADDR_W   (8),
      .RESET_PC (8'hF4),
      .STEP     (4)
   ) dut_w (
      .clk         (clk),
      .rst         (rst),
      .stall_i     (1'b0),
      .req_ready_i (1'b1),
      .flush_i     (1'b0),
      .flush_pc_i  (8'h00),
      .br_flag_i   (1'b0),
      .br_target_i (8'h00),
      .pc_o        (w_pc),
      .ce_o        (w_ce),
      .redir_o     (w_redir),
      .misalign_o  (w_mis)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst         = 1'b1;
      stall_i     = 1'b0;
      req_ready_i = 1'b1;
      flush_i     = 1'b0;
      flush_pc_i  = '0;
      br_flag_i   = 1'b0;
      br_target_i = '0;

      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_ce", 32'(ce_o), 32'd0);
         check("rst_pc", pc_o, 32'h0);
         check("rst_mis", 32'(misalign_o), 32'd0);
      end

      rst = 1'b0;
      tick();
      check("first_ce", 32'(ce_o), 32'd1);
      check("first_pc", pc_o, 32'h0);
      check("w_pc0", 32'(w_pc), 32'hF4);
      tick();
      check("seq_4", pc_o, 32'h4);
      check("w_pc1", 32'(w_pc), 32'hF8);
      tick();
      check("seq_8", pc_o, 32'h8);
      check("w_pc2", 32'(w_pc), 32'hFC);
      tick();
      check("seq_c", pc_o, 32'hC);
      check("w_wrap", 32'(w_pc), 32'h00);
      check("seq_redir", 32'(redir_o), 32'd0);
      tick();
      check("seq_10", pc_o, 32'h10);

      stall_i = 1'b1;
      tick();
      check("stall_a", pc_o, 32'h10);
      tick();
      check("stall_b", pc_o, 32'h10);
      check("stall_ce", 32'(ce_o), 32'd1);
      stall_i     = 1'b0;
      req_ready_i = 1'b0;
      tick();
      check("nrdy", pc_o, 32'h10);
      req_ready_i = 1'b1;
      tick();
      check("resume", pc_o, 32'h14);

      req_ready_i = 1'b0;
      br_flag_i   = 1'b1;
      br_target_i = 32'h100;
      tick();
      check("pend_hold0", pc_o, 32'h14);
      br_flag_i = 1'b0;
      tick();
      check("pend_hold1", pc_o, 32'h14);
      tick();
      check("pend_hold2", pc_o, 32'h14);
      check("pend_ce", 32'(ce_o), 32'd1);
      req_ready_i = 1'b1;
      tick();
      check("pend_tgt", pc_o, 32'h100);
      check("pend_redir", 32'(redir_o), 32'd1);
      tick();
      check("pend_next", pc_o, 32'h104);
      check("pend_redir0", 32'(redir_o), 32'd0);

      req_ready_i = 1'b0;
      br_flag_i   = 1'b1;
      br_target_i = 32'h300;
      tick();
      check("prio_pend", pc_o, 32'h104);
      flush_i     = 1'b1;
      flush_pc_i  = 32'h380;
      br_target_i = 32'h200;
      req_ready_i = 1'b1;
      tick();
      check("prio_flush", pc_o, 32'h380);
      check("prio_redir", 32'(redir_o), 32'd1);
      flush_i   = 1'b0;
      br_flag_i = 1'b0;
      tick();
      check("prio_next", pc_o, 32'h384);

      stall_i    = 1'b1;
      flush_i    = 1'b1;
      flush_pc_i = 32'h500;
      tick();
      check("flush_stall", pc_o, 32'h500);
      stall_i = 1'b0;
      flush_i = 1'b0;
      tick();
      check("flush_next", pc_o, 32'h504);

      br_flag_i   = 1'b1;
      br_target_i = 32'h102;
      tick();
      check("mis_pc", pc_o, 32'h102);
`ifdef PC_ALIGN_CHECK_EN
      check("mis_ce", 32'(ce_o), 32'd0);
      check("mis_flag", 32'(misalign_o), 32'd1);
`else
      check("mis_ce", 32'(ce_o), 32'd1);
      check("mis_flag", 32'(misalign_o), 32'd0);
`endif
      br_flag_i = 1'b0;
      tick();
`ifdef PC_ALIGN_CHECK_EN
      check("err_hold", pc_o, 32'h102);
      check("err_flag", 32'(misalign_o), 32'd1);
`else
      check("mis_step", pc_o, 32'h106);
      check("mis_flag2", 32'(misalign_o), 32'd0);
`endif
      br_flag_i   = 1'b1;
      br_target_i = 32'h200;
      tick();
`ifdef PC_ALIGN_CHECK_EN
      check("err_br", pc_o, 32'h102);
      check("err_ce", 32'(ce_o), 32'd0);
`else
      check("br_200", pc_o, 32'h200);
      check("br_ce", 32'(ce_o), 32'd1);
`endif
      br_flag_i  = 1'b0;
      flush_i    = 1'b1;
      flush_pc_i = 32'h380;
      tick();
      check("rec_pc", pc_o, 32'h380);
      check("rec_ce", 32'(ce_o), 32'd1);
      check("rec_mis", 32'(misalign_o), 32'd0);
      flush_i = 1'b0;
      tick();
      check("rec_next", pc_o, 32'h384);

      rst = 1'b1;
      tick();
      check("rerst_pc", pc_o, 32'h0);
      check("rerst_ce", 32'(ce_o), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
